// File: rtl/dcm_sp_fx.sv
//------------------------------------------------------------------------------
// Module      : dcm_sp_fx
// Description : Behavioral clock-synthesis model. Measures the CLKIN period,
//               locks after LOCK_CYCLES stable periods and generates CLKFX at
//               M/D times the CLKIN frequency, re-aligned every D input cycles.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module dcm_sp_fx #(
  parameter int CLKFX_MULTIPLY = 4,
  parameter int CLKFX_DIVIDE   = 1,
  parameter int LOCK_CYCLES    = 8,
  parameter int TOL_PPM        = 1000
) (
  input  wire logic CLKIN,
  input  wire logic RST,
  output logic      CLK0,
  output logic      CLKFX,
  output logic      CLKFX180,
  output logic      LOCKED
);

  localparam bit PARAM_OK = (CLKFX_MULTIPLY >= 2) && (CLKFX_MULTIPLY <= 32) &&
                            (CLKFX_DIVIDE >= 1) && (CLKFX_DIVIDE <= 32);

  localparam longint M_L = longint'(CLKFX_MULTIPLY);
  localparam longint D_L = longint'(CLKFX_DIVIDE);
  localparam longint TOL = longint'(TOL_PPM);

  localparam logic [1:0] S_RESET   = 2'd0;
  localparam logic [1:0] S_ACQUIRE = 2'd1;
  localparam logic [1:0] S_LOCKED  = 2'd2;

  logic [1:0] state     = S_RESET;
  logic       locked    = 1'b0;
  logic       fx        = 1'b0;
  logic       have_edge = 1'b0;
  int         count     = 0;
  int         div_cnt   = 0;
  // Generation tokens: a pending timed action only fires if its token is
  // still current, which is how reset / re-alignment kill stale toggles.
  int         fx_epoch  = 0;
  int         wd_epoch  = 0;
  longint     t_last    = 64'sd0;
  longint     tin       = 64'sd0;   // last measured period, ps (0 = none yet)
  longint     tnew      = 64'sd0;
  longint     now       = 64'sd0;

  // Report illegal multiply/divide settings once at time zero.
  initial begin
    if (!PARAM_OK)
      $display("ERROR: %m illegal CLKFX_MULTIPLY=%0d / CLKFX_DIVIDE=%0d, LOCKED held low",
               CLKFX_MULTIPLY, CLKFX_DIVIDE);
  end

  function automatic longint now_ps();
    return longint'($realtime * 1000.0);
  endfunction

  function automatic bit stable(input longint t_new, input longint t_prev);
    longint diff;
    diff = (t_new >= t_prev) ? (t_new - t_prev) : (t_prev - t_new);
    return (diff * 64'sd1000000) <= (t_prev * TOL);
  endfunction

  // One alignment window: M rising edges spread over D input periods.
  // Rise k is placed at t0 + round(k*Tfx) so no drift builds up inside the
  // window; the high phase is Tfx/2 truncated to 1 ps.
  task automatic run_fx(input int e, input longint t0, input longint tin_ps);
    longint tr;
    longint tf;
    for (int k = 0; k < CLKFX_MULTIPLY; k++) begin
      tr = t0 + (longint'(k) * tin_ps * D_L * 64'sd2 + M_L) / (64'sd2 * M_L);
      if (tr > now_ps()) #(real'(tr - now_ps()) / 1000.0);
      if (e != fx_epoch) return;
      fx = 1'b1;
      tf = tr + (tin_ps * D_L) / (64'sd2 * M_L);
      if (tf > now_ps()) #(real'(tf - now_ps()) / 1000.0);
      if (e != fx_epoch) return;
      fx = 1'b0;
    end
  endtask

  // Missing-edge detector: drops lock if no newer CLKIN edge arrived in time.
  task automatic watchdog(input int e, input longint span_ps);
    #(real'(span_ps) / 1000.0);
    if ((e == wd_epoch) && (state == S_LOCKED)) begin
      state     = S_ACQUIRE;
      locked    = 1'b0;
      fx        = 1'b0;
      fx_epoch  = fx_epoch + 1;
      count     = 0;
      have_edge = 1'b0;
      tin       = 64'sd0;
    end
  endtask

  // Period measurement, lock state machine and CLKFX alignment control.
  always begin
    @(posedge CLKIN or negedge RST);
    if (!RST) begin
      state     = S_RESET;
      locked    = 1'b0;
      fx        = 1'b0;
      fx_epoch  = fx_epoch + 1;
      wd_epoch  = wd_epoch + 1;
      count     = 0;
      div_cnt   = 0;
      have_edge = 1'b0;
      tin       = 64'sd0;
      t_last    = 64'sd0;
    end else begin
      now      = now_ps();
      wd_epoch = wd_epoch + 1;
      case (state)
        S_RESET: begin
          // This edge only opens the first measurement interval.
          state     = S_ACQUIRE;
          have_edge = 1'b1;
          t_last    = now;
          tin       = 64'sd0;
          count     = 0;
        end
        S_ACQUIRE: begin
          if (!have_edge) begin
            have_edge = 1'b1;
            t_last    = now;
          end else begin
            tnew   = now - t_last;
            t_last = now;
            // The very first period has nothing to compare with, so it
            // starts the run of stable periods.
            if ((tin == 64'sd0) || stable(tnew, tin)) begin
              if (count < LOCK_CYCLES) count = count + 1;
            end else begin
              count = 0;
            end
            tin = tnew;
            if (PARAM_OK && (count >= LOCK_CYCLES)) begin
              state    = S_LOCKED;
              locked   = 1'b1;
              div_cnt  = 0;
              fx_epoch = fx_epoch + 1;
              fx       = 1'b1;
              fork
                run_fx(fx_epoch, now, tin);
              join_none
            end
          end
        end
        S_LOCKED: begin
          tnew   = now - t_last;
          t_last = now;
          if (!stable(tnew, tin)) begin
            state    = S_ACQUIRE;
            locked   = 1'b0;
            fx       = 1'b0;
            fx_epoch = fx_epoch + 1;
            count    = 0;
            tin      = tnew;
          end else begin
            tin     = tnew;
            div_cnt = div_cnt + 1;
            if (div_cnt >= CLKFX_DIVIDE) begin
              // Re-align: restart the window on this CLKIN edge.
              div_cnt  = 0;
              fx_epoch = fx_epoch + 1;
              fx       = 1'b1;
              fork
                run_fx(fx_epoch, now, tin);
              join_none
            end
          end
        end
        default: state = S_RESET;
      endcase
      if (state == S_LOCKED) begin
        fork
          watchdog(wd_epoch, 64'sd2 * tin);
        join_none
      end
    end
  end

  assign CLK0     = locked & CLKIN;
  assign CLKFX    = fx;
  assign CLKFX180 = locked & ~fx;
  assign LOCKED   = locked;

endmodule

`default_nettype wire

// File: tb/tb_dcm_sp_fx.sv
//------------------------------------------------------------------------------
// Module      : tb_dcm_sp_fx
// Description : Self-checking bench for dcm_sp_fx (M=11/D=7 and M=2/D=1).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_dcm_sp_fx;

  logic clkin = 1'b0;
  logic clk2  = 1'b0;
  logic rst   = 1'b0;
  logic clk0_a, fx_a, fx180_a, lk_a;
  logic clk0_b, fx_b, fx180_b, lk_b;

  int per_ps = 20000;
  bit hold   = 1'b0;
  bit jit    = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string  tag;
    longint val;
  } exp_t;
  exp_t sb[$];

  longint fxa_rise[$];
  longint fxb_rise[$];
  longint fxb_fall[$];
  longint lka_fall[$];

  dcm_sp_fx #(.CLKFX_MULTIPLY(11), .CLKFX_DIVIDE(7)) dut (
    .CLKIN(clkin), .RST(rst), .CLK0(clk0_a), .CLKFX(fx_a),
    .CLKFX180(fx180_a), .LOCKED(lk_a)
  );

  dcm_sp_fx #(.CLKFX_MULTIPLY(2), .CLKFX_DIVIDE(1)) dut2 (
    .CLKIN(clk2), .RST(rst), .CLK0(clk0_b), .CLKFX(fx_b),
    .CLKFX180(fx180_b), .LOCKED(lk_b)
  );

  function automatic longint now_ps();
    return longint'($realtime * 1000.0);
  endfunction

  // Fixed 10 ns reference for the M/D = 2 instance.
  always #5 clk2 = ~clk2;

  // Programmable CLKIN: period, optional +-10 ps jitter, hold-low.
  initial begin : gen
    int p;
    int jt[4];
    int ji;
    jt = '{10, 0, -10, 0};
    ji = 0;
    #5;
    forever begin
      if (hold) begin
        wait (!hold);
        #10;
      end
      p = per_ps;
      if (jit) begin
        p  = p + jt[ji];
        ji = (ji + 1) % 4;
      end
      clkin = 1'b1;
      #(real'(p / 2) / 1000.0);
      clkin = 1'b0;
      #(real'(p - p / 2) / 1000.0);
    end
  end

  // Edge logs of DUT outputs.
  always @(posedge fx_a) fxa_rise.push_back(now_ps());
  always @(posedge fx_b) fxb_rise.push_back(now_ps());
  always @(negedge fx_b) fxb_fall.push_back(now_ps());
  always @(negedge lk_a) lka_fall.push_back(now_ps());

  // Overall time limit.
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 ns");
    $fatal(1, "timeout");
  end

  task automatic expect_val(input string tag, input longint v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic observe(input longint obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %0d, expected nothing", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %0d, expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  // Counts CLKIN rising edges (starting with the next one) until LOCKED is high.
  task automatic lock_edges(output int n, output longint t_lock);
    n      = -1;
    t_lock = 64'sd0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clkin);
      t_lock = now_ps();
      #1;
      if (lk_a === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin : main
    int     n;
    int     bad;
    int     found;
    longint t0;
    longint tl;
    longint w[$];
    longint r0;
    longint per;
    longint hi;

    // Reset state of both instances.
    #33;
    expect_val("reset_outputs", 0);
    observe(longint'({lk_a, fx_a, fx180_a, clk0_a, lk_b, fx_b, fx180_b, clk0_b}));

    // Release and count edges to lock at M=11 D=7, CLKIN 20 ns.
    @(negedge clkin);
    #1;
    rst = 1'b1;
    fxa_rise.delete();
    expect_val("lock_edges_after_release", 9);
    lock_edges(n, t0);
    observe(longint'(n));

    // CLKFX behaviour over one 140 ns alignment window.
    #150;
    w.delete();
    foreach (fxa_rise[i])
      if ((fxa_rise[i] >= t0) && (fxa_rise[i] < t0 + 64'sd140000)) w.push_back(fxa_rise[i]);
    expect_val("fx_rises_per_140ns", 11);
    observe(longint'(w.size()));
    expect_val("fx_rise_at_lock_edge", 0);
    observe((w.size() > 0) ? (w[0] - t0) : -64'sd1);
    bad = 0;
    for (int i = 1; i < w.size(); i++)
      if ((w[i] - w[i-1] < 64'sd12726) || (w[i] - w[i-1] > 64'sd12728)) bad++;
    expect_val("fx_period_12727ps_out_of_tol", 0);
    observe(longint'(bad));
    found = 0;
    foreach (fxa_rise[i]) if (fxa_rise[i] == t0 + 64'sd140000) found = 1;
    expect_val("fx_realign_on_7th_clkin", 1);
    observe(longint'(found));

    // M=2 D=1 instance: 5 ns period, 2.5 ns high, phase on the 5 ns grid.
    fxb_rise.delete();
    fxb_fall.delete();
    #30;
    r0  = (fxb_rise.size() >= 2) ? fxb_rise[0] : -64'sd1;
    per = (fxb_rise.size() >= 2) ? (fxb_rise[1] - fxb_rise[0]) : -64'sd1;
    hi  = -64'sd1;
    foreach (fxb_fall[i]) if ((hi < 0) && (r0 >= 0) && (fxb_fall[i] > r0)) hi = fxb_fall[i] - r0;
    expect_val("fx2_locked", 1);
    observe(longint'(lk_b));
    expect_val("fx2_period_ps", 5000);
    observe(per);
    expect_val("fx2_high_ps", 2500);
    observe(hi);
    expect_val("fx2_rise_phase", 0);
    observe((r0 >= 0) ? (r0 % 64'sd5000) : -64'sd1);
    #0.3;
    repeat (6) begin
      expect_val("fx2_inverse_and_clk0", 3);
      observe(longint'({fx180_b === ~fx_b, clk0_b === clk2}));
      #1;
    end

    // Jitter of +-10 ps on 20 ns must not disturb lock.
    lka_fall.delete();
    jit = 1'b1;
    repeat (40) @(posedge clkin);
    jit = 1'b0;
    #1;
    expect_val("jitter_lock_held", 1);
    observe(longint'((lka_fall.size() == 0) && (lk_a === 1'b1)));

    // CLKIN held low: lock drops 2*Tin after the last rising edge.
    @(posedge clkin);
    tl = now_ps();
    #1;
    hold = 1'b1;
    lka_fall.delete();
    #100;
    expect_val("hold_low_drop_delay_ps", 40000);
    observe((lka_fall.size() == 1) ? (lka_fall[0] - tl) : -64'sd1);
    expect_val("hold_low_outputs", 0);
    observe(longint'({lk_a, fx_a, fx180_a, clk0_a}));
    hold = 1'b0;
    expect_val("relock_after_resume", 9);
    lock_edges(n, t0);
    observe(longint'(n));

    // Reset asserted inside a CLKFX high phase.
    #20;
    for (int i = 0; i < 300; i++) begin
      if (fx_a === 1'b1) break;
      #0.1;
    end
    #1;
    expect_val("fx_high_before_reset", 1);
    observe(longint'(fx_a));
    rst = 1'b0;
    fxa_rise.delete();
    #0.001;
    expect_val("reset_mid_pulse_outputs", 0);
    observe(longint'({lk_a, fx_a, fx180_a, clk0_a}));
    #15;
    expect_val("no_fx_rise_in_reset", 0);
    observe(longint'(fxa_rise.size()));
    @(negedge clkin);
    #1;
    rst = 1'b1;
    expect_val("relock_after_reset", 9);
    lock_edges(n, t0);
    observe(longint'(n));

    // Period change 20 ns -> 25 ns.
    @(posedge clkin);
    #1;
    per_ps = 25000;
    @(posedge clkin);
    n = -1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clkin);
      #1;
      if (lk_a !== 1'b1) begin
        n = i;
        break;
      end
    end
    expect_val("drop_at_first_25ns_edge", 1);
    observe(longint'(n));
    fxa_rise.delete();
    lock_edges(n, t0);
    expect_val("relock_at_25ns", 1);
    observe(longint'(n > 0));
    #40;
    w.delete();
    foreach (fxa_rise[i]) if (fxa_rise[i] >= t0) w.push_back(fxa_rise[i]);
    expect_val("fx_period_15909ps", 1);
    observe(longint'((w.size() >= 2) && (w[1] - w[0] >= 64'sd15908) && (w[1] - w[0] <= 64'sd15910)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
